// File: rtl/cpu_bus_responder.sv
// Byte-wide RAM responder for the CPU rdwr bus with programmable wait states and CPU stall.
// Optional write protection above WP_BASE is enabled by defining CPU_BUS_RESPONDER_WP_EN.
module cpu_bus_responder #(
  parameter int          MEM_ADDR_BITS = 12,
  parameter int          WAIT_STATES   = 2,
  parameter logic [15:0] WP_BASE       = 16'hF000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_rdwr,
  input  logic        which_rdwr,
  input  logic [15:0] addr,
  input  logic [7:0]  wr_data,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        cpu_enable,
  output logic        wp_fault
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nxt;
  logic [3:0]  cnt;
  logic [15:0] lat_addr;
  logic        lat_we;
  logic [7:0]  lat_wdata;
  logic [7:0]  mem [2**MEM_ADDR_BITS];

  logic [MEM_ADDR_BITS-1:0] mem_idx;
  logic finish, wp_hit, do_read, do_write, enable_nxt;

  assign mem_idx = lat_addr[MEM_ADDR_BITS-1:0];
  assign finish  = (state == BUSY) && (cnt == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A request seen in IDLE or DONE is accepted; BUSY ignores req_rdwr.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = req_rdwr ? BUSY : IDLE;
      BUSY:       if (cnt == 4'd0) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    do_read    = finish && !lat_we;
    do_write   = finish && lat_we && !wp_hit;
    enable_nxt = (state_nxt != BUSY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 4'd0;
      lat_addr   <= 16'h0000;
      lat_we     <= 1'b0;
      lat_wdata  <= 8'h00;
      rd_data    <= 8'h00;
      rd_valid   <= 1'b0;
      cpu_enable <= 1'b1;
    end else begin
      cpu_enable <= enable_nxt;
      rd_valid   <= do_read;
      if (do_read) rd_data <= mem[mem_idx];
      if (state != BUSY) begin
        if (req_rdwr) begin
          lat_addr  <= addr;
          lat_we    <= which_rdwr;
          lat_wdata <= wr_data;
          cnt       <= 4'(WAIT_STATES);
        end
      end else if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // RAM is deliberately not reset; a reset mid-access leaves state IDLE so the write never fires.
  always_ff @(posedge clk) begin
    if (do_write) mem[mem_idx] <= lat_wdata;
  end

`ifdef CPU_BUS_RESPONDER_WP_EN
  assign wp_hit = lat_we && (lat_addr >= WP_BASE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wp_fault <= 1'b0;
    else     wp_fault <= finish && wp_hit;
  end
`else
  logic unused_hi;

  assign wp_hit    = 1'b0;
  assign wp_fault  = 1'b0;
  assign unused_hi = ^{lat_addr[15:MEM_ADDR_BITS], WP_BASE};
`endif

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Bench for cpu_bus_responder: vector table, reset/back-to-back sequences, random ops vs. a memory model.
module tb_cpu_bus_responder;

  localparam int WS = 2;
`ifdef CPU_BUS_RESPONDER_WP_EN
  localparam logic WP = 1'b1;
`else
  localparam logic WP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, which = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [7:0]  wdata = 8'h0;
  logic [7:0]  rd_data;
  logic        rd_valid, cpu_enable, wp_fault;

  logic        req0 = 1'b0, which0 = 1'b0;
  logic [15:0] addr0 = 16'h0;
  logic [7:0]  wdata0 = 8'h0;
  logic [7:0]  rd_data0;
  logic        rd_valid0, cpu_enable0, wp_fault0;

  always #5 clk = ~clk;

  cpu_bus_responder #(.MEM_ADDR_BITS(12), .WAIT_STATES(WS), .WP_BASE(16'hF000)) dut (
    .clk(clk), .rst(rst), .req_rdwr(req), .which_rdwr(which), .addr(addr), .wr_data(wdata),
    .rd_data(rd_data), .rd_valid(rd_valid), .cpu_enable(cpu_enable), .wp_fault(wp_fault));

  cpu_bus_responder #(.MEM_ADDR_BITS(12), .WAIT_STATES(0), .WP_BASE(16'hF000)) dut0 (
    .clk(clk), .rst(rst), .req_rdwr(req0), .which_rdwr(which0), .addr(addr0), .wr_data(wdata0),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .cpu_enable(cpu_enable0), .wp_fault(wp_fault0));

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        we;
    logic [15:0] a;
    logic [7:0]  d;
    logic        exp_vld;
    logic [7:0]  exp_rd;
    logic        exp_flt;
  } vec_t;

  vec_t vecs[10];
  logic [7:0] model [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one access on the WS=2 instance and observe stall length and DONE-cycle outputs.
  task automatic access(input logic we, input logic [15:0] a, input logic [7:0] d,
                        output int low, output logic vld, output logic [7:0] rdv,
                        output logic flt, output logic lingering);
    @(negedge clk);
    req = 1'b1; which = we; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    low = 0;
    for (int i = 0; i < 40; i++) begin
      if (cpu_enable) break;
      low++;
      @(posedge clk); #1;
    end
    vld = rd_valid; rdv = rd_data; flt = wp_fault;
    @(posedge clk); #1;
    lingering = rd_valid | wp_fault;
  endtask

  function automatic logic protected_addr(input logic [15:0] a);
    return WP && (a >= 16'hF000);
  endfunction

  initial begin
    int low;
    logic vld, flt, ling;
    logic [7:0] rdv;
    logic [15:0] ra;
    logic [7:0] rdat;
    logic rwe;
    logic [11:0] pool[6];

    vecs[0] = '{1'b1, 16'h0123, 8'hA5, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 16'h0123, 8'h00, 1'b1, 8'hA5, 1'b0};
    vecs[2] = '{1'b1, 16'h1010, 8'h3C, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{1'b0, 16'h0010, 8'h00, 1'b1, 8'h3C, 1'b0};
    vecs[4] = '{1'b1, 16'h0200, 8'h11, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{1'b0, 16'h0200, 8'h00, 1'b1, 8'h11, 1'b0};
    vecs[6] = '{1'b1, 16'h0004, 8'h5A, 1'b0, 8'h00, 1'b0};
    vecs[7] = '{1'b1, 16'hF004, 8'h77, 1'b0, 8'h00, WP};
    vecs[8] = '{1'b0, 16'hF004, 8'h00, 1'b1, WP ? 8'h5A : 8'h77, 1'b0};
    vecs[9] = '{1'b0, 16'h0004, 8'h00, 1'b1, WP ? 8'h5A : 8'h77, 1'b0};

    // Release reset between edges; outputs must show reset values.
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("reset_outs", {cpu_enable, rd_valid, wp_fault, rd_data}, {1'b1, 1'b0, 1'b0, 8'h00});
    check("reset_outs0", {cpu_enable0, rd_valid0, wp_fault0, rd_data0}, {1'b1, 1'b0, 1'b0, 8'h00});

    for (int i = 0; i < 10; i++) begin
      access(vecs[i].we, vecs[i].a, vecs[i].d, low, vld, rdv, flt, ling);
      check($sformatf("vec%0d_stall", i), low, WS + 1);
      check($sformatf("vec%0d_vld_flt", i), {vld, flt}, {vecs[i].exp_vld, vecs[i].exp_flt});
      check($sformatf("vec%0d_pulse_end", i), ling, 1'b0);
      if (vecs[i].exp_vld) check($sformatf("vec%0d_data", i), rdv, vecs[i].exp_rd);
      if (vecs[i].we && !protected_addr(vecs[i].a)) model[int'(vecs[i].a & 16'h0FFF)] = vecs[i].d;
    end

    // Reset while BUSY on a write: stall drops immediately and the write is lost.
    @(negedge clk);
    req = 1'b1; which = 1'b1; addr = 16'h0200; wdata = 8'hFF;
    @(posedge clk); #1;
    req = 1'b0;
    check("rst_busy_stall", cpu_enable, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst_async_outs", {cpu_enable, rd_valid, wp_fault, rd_data}, {1'b1, 1'b0, 1'b0, 8'h00});
    @(negedge clk);
    rst = 1'b0;
    access(1'b0, 16'h0200, 8'h00, low, vld, rdv, flt, ling);
    check("rst_write_dropped", {vld, rdv}, {1'b1, 8'h11});

    // WS=0 instance with req held: write then a stream of reads, one every 2 cycles.
    @(negedge clk);
    req0 = 1'b1; which0 = 1'b1; addr0 = 16'h0050; wdata0 = 8'h42;
    for (int i = 1; i <= 10; i++) begin
      logic exp_en, exp_vld;
      @(posedge clk); #1;
      exp_en  = (i % 2 == 0);
      exp_vld = (i % 2 == 0) && (i >= 4);
      check($sformatf("b2b_cyc%0d", i), {cpu_enable0, rd_valid0, wp_fault0}, {exp_en, exp_vld, 1'b0});
      if (exp_vld) check($sformatf("b2b_data%0d", i), rd_data0, 8'h42);
      if (i == 1) which0 = 1'b0;
      if (i == 9) req0 = 1'b0;
    end

    // Random traffic against a byte-array model with aliasing and protection.
    pool = '{12'h123, 12'h010, 12'h200, 12'h004, 12'h7FF, 12'hABC};
    for (int n = 0; n < 40; n++) begin
      ra   = {4'($urandom_range(0, 15)), pool[$urandom_range(0, 5)]};
      rwe  = 1'($urandom_range(0, 1));
      rdat = 8'($urandom);
      access(rwe, ra, rdat, low, vld, rdv, flt, ling);
      check($sformatf("rnd%0d_stall", n), low, WS + 1);
      check($sformatf("rnd%0d_vld_flt", n), {vld, flt}, {!rwe, rwe && protected_addr(ra)});
      if (rwe) begin
        if (!protected_addr(ra)) model[int'(ra & 16'h0FFF)] = rdat;
      end else if (model.exists(int'(ra & 16'h0FFF))) begin
        check($sformatf("rnd%0d_data", n), rdv, model[int'(ra & 16'h0FFF)]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
